// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: nop encoding, per-boundary payload widths and
// field offsets used to pack/unpack stage payloads into a pipe_skid_stage.
package pipe_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0;

   // IF/ID payload: {instr, pc}
   localparam int IF_ID_PC_OFF    = 0;
   localparam int IF_ID_INSTR_OFF = 32;
   localparam int IF_ID_W         = 64;

   // ID/EX payload: {ext, rt_data, instr, pc}
   localparam int ID_EX_PC_OFF    = 0;
   localparam int ID_EX_INSTR_OFF = 32;
   localparam int ID_EX_RT_OFF    = 64;
   localparam int ID_EX_EXT_OFF   = 96;
   localparam int ID_EX_W         = 128;

   // EX/MEM payload: {jump, rt_data, alu_res, pc}
   localparam int EX_MEM_PC_OFF   = 0;
   localparam int EX_MEM_ALU_OFF  = 32;
   localparam int EX_MEM_RT_OFF   = 64;
   localparam int EX_MEM_JMP_OFF  = 96;
   localparam int EX_MEM_W        = 97;

   // MEM/WB payload: {jump, mdu_res, alu_res, pc}
   localparam int MEM_WB_PC_OFF   = 0;
   localparam int MEM_WB_ALU_OFF  = 32;
   localparam int MEM_WB_MDU_OFF  = 64;
   localparam int MEM_WB_JMP_OFF  = 96;
   localparam int MEM_WB_W        = 97;

   // Widest boundary; default stage width
   localparam int PIPE_MAX_W      = 128;

   // Pack an IF/ID payload
   function automatic logic [IF_ID_W-1:0] pack_if_id(input logic [31:0] pc,
                                                    input logic [31:0] instr);
      logic [IF_ID_W-1:0] p;
      p = '0;
      p[IF_ID_PC_OFF    +: 32] = pc;
      p[IF_ID_INSTR_OFF +: 32] = instr;
      return p;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clr wins.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear, saturating increment, or hold
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && !(&cnt_q))
         cnt_d = cnt_q + 1'b1;
   end

   // Count register
   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline stage with a 2-entry skid buffer.
// in_ready is a pure register output (= ~skid valid). Flush empties the stage
// and both data registers fall back to BUBBLE_VAL whenever a slot empties.
// Optional statistics counters (stall_cnt, flush_cnt) are built only when the
// macro PIPE_STAGE_STATS_EN is defined.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int                DATA_W     = PIPE_MAX_W,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
   parameter int                CNT_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
`ifdef PIPE_STAGE_STATS_EN
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`else
   output logic [DATA_W-1:0] out_data
`endif
);

   logic              main_v_q, main_v_d;
   logic [DATA_W-1:0] main_d_q, main_d_d;
   logic              skid_v_q, skid_v_d;
   logic [DATA_W-1:0] skid_d_q, skid_d_d;
   logic              acc;
   logic              emt;

   assign acc = in_valid & ~skid_v_q;
   assign emt = main_v_q & out_ready;

   // Occupancy transitions EMPTY / ONE / FULL; flush overrides everything
   always_comb begin
      main_v_d = main_v_q;
      main_d_d = main_d_q;
      skid_v_d = skid_v_q;
      skid_d_d = skid_d_q;
      if (flush) begin
         main_v_d = 1'b0;
         main_d_d = BUBBLE_VAL;
         skid_v_d = 1'b0;
         skid_d_d = BUBBLE_VAL;
      end else if (!main_v_q) begin
         // EMPTY: skid is never occupied while main is empty
         if (acc) begin
            main_v_d = 1'b1;
            main_d_d = in_data;
         end
      end else if (!skid_v_q) begin
         // ONE
         if (acc && emt) begin
            main_d_d = in_data;
         end else if (acc) begin
            skid_v_d = 1'b1;
            skid_d_d = in_data;
         end else if (emt) begin
            main_v_d = 1'b0;
            main_d_d = BUBBLE_VAL;
         end
      end else begin
         // FULL: no accept possible; drain skid into main on emit
         if (emt) begin
            main_d_d = skid_d_q;
            skid_v_d = 1'b0;
            skid_d_d = BUBBLE_VAL;
         end
      end
   end

   // Slot registers; reset returns both slots to empty bubbles
   always_ff @(posedge clk) begin
      if (reset) begin
         main_v_q <= 1'b0;
         main_d_q <= BUBBLE_VAL;
         skid_v_q <= 1'b0;
         skid_d_q <= BUBBLE_VAL;
      end else begin
         main_v_q <= main_v_d;
         main_d_q <= main_d_d;
         skid_v_q <= skid_v_d;
         skid_d_q <= skid_d_d;
      end
   end

   assign in_ready  = ~skid_v_q;
   assign out_valid = main_v_q;
   assign out_data  = main_d_q;

`ifdef PIPE_STAGE_STATS_EN
   logic stall_inc;
   logic flush_inc;

   assign stall_inc = main_v_q & ~out_ready & ~flush;
   assign flush_inc = flush & (main_v_q | skid_v_q);

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .clr (reset),
      .inc (stall_inc),
      .cnt (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .clr (reset),
      .inc (flush_inc),
      .cnt (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: a table of per-cycle vectors for the
// main datapath plus hand sequences for reset, bubble value and saturation.
// Counter checks are compiled in when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_skid_stage;

   logic        clk = 1'b0;
   logic        reset;

   logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [31:0] a_in_data, a_out_data;

   logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [31:0] b_in_data, b_out_data;

`ifdef PIPE_STAGE_STATS_EN
   logic [31:0] a_stall_cnt, a_flush_cnt;
   logic [3:0]  b_stall_cnt, b_flush_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_skid_stage #(.DATA_W(32), .BUBBLE_VAL(32'h0), .CNT_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (a_flush),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_data   (a_in_data),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
`ifdef PIPE_STAGE_STATS_EN
      .out_data  (a_out_data),
      .stall_cnt (a_stall_cnt),
      .flush_cnt (a_flush_cnt)
`else
      .out_data  (a_out_data)
`endif
   );

   pipe_skid_stage #(.DATA_W(32), .BUBBLE_VAL(32'hDEAD), .CNT_W(4)) dut_b (
      .clk       (clk),
      .reset     (reset),
      .flush     (b_flush),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
`ifdef PIPE_STAGE_STATS_EN
      .out_data  (b_out_data),
      .stall_cnt (b_stall_cnt),
      .flush_cnt (b_flush_cnt)
`else
      .out_data  (b_out_data)
`endif
   );

   typedef struct {
      logic        iv;
      logic [31:0] id;
      logic        ordy;
      logic        fl;
      logic        ev;
      logic [31:0] ed;
      logic        erdy;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic iv, input logic [31:0] id, input logic ordy, input logic fl,
                      input logic ev, input logic [31:0] ed, input logic erdy);
      vec_t v;
      v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
      v.ev = ev; v.ed = ed; v.erdy = erdy;
      vecs.push_back(v);
   endtask

   initial begin
      logic        prev_v;
      logic        prev_rdy;
`ifdef PIPE_STAGE_STATS_EN
      logic [31:0] exp_stall;
      logic [31:0] exp_flushc;
`endif

      reset = 1'b1;
      a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hFFFF_0001; a_out_ready = 1'b0;
      b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 32'h0;         b_out_ready = 1'b0;

      // Reset held two cycles, even with in_valid asserted
      tick();
      tick();
      check("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
      a_in_valid = 1'b0;
      reset = 1'b0;
      tick();
      check("rst_out_valid_rel", {31'b0, a_out_valid}, 32'd0);
      check("rst_in_ready",      {31'b0, a_in_ready},  32'd1);
      check("rst_out_data",      a_out_data,           32'd0);
      check("rst_b_out_data",    b_out_data,           32'hDEAD);
`ifdef PIPE_STAGE_STATS_EN
      check("rst_stall_cnt", a_stall_cnt, 32'd0);
      check("rst_flush_cnt", a_flush_cnt, 32'd0);
`endif

      // Streaming A1..A8 at full throughput
      for (int i = 1; i <= 8; i++)
         add(1'b1, 32'hA0 + 32'(i), 1'b1, 1'b0, 1'b1, 32'hA0 + 32'(i), 1'b1);
      add(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1);
      // Backpressure: fill to FULL, blocked offer, then drain in order
      add(1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 32'h11, 1'b1);
      add(1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
      add(1'b1, 32'h99, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
      add(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h22, 1'b1);
      add(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1);
      // out_ready with nothing held
      add(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1);
      // FULL then flush with an offered payload that must be dropped
      add(1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 32'h44, 1'b1);
      add(1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 32'h44, 1'b0);
      add(1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1);
      add(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1);
      // Flush in ONE while emitting and offering
      add(1'b1, 32'h66, 1'b1, 1'b0, 1'b1, 32'h66, 1'b1);
      add(1'b1, 32'h77, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1);
      // Accept-and-emit in ONE, then emit-only to EMPTY
      add(1'b1, 32'h81, 1'b0, 1'b0, 1'b1, 32'h81, 1'b1);
      add(1'b1, 32'h82, 1'b1, 1'b0, 1'b1, 32'h82, 1'b1);
      add(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1);

      prev_v = 1'b0;
      prev_rdy = 1'b1;
`ifdef PIPE_STAGE_STATS_EN
      exp_stall = 32'd0;
      exp_flushc = 32'd0;
`endif
      foreach (vecs[i]) begin
         a_in_valid  = vecs[i].iv;
         a_in_data   = vecs[i].id;
         a_out_ready = vecs[i].ordy;
         a_flush     = vecs[i].fl;
`ifdef PIPE_STAGE_STATS_EN
         if (prev_v && !vecs[i].ordy && !vecs[i].fl) exp_stall++;
         if (vecs[i].fl && (prev_v || !prev_rdy)) exp_flushc++;
`endif
         tick();
         check($sformatf("vec%0d_out_valid", i), {31'b0, a_out_valid}, {31'b0, vecs[i].ev});
         check($sformatf("vec%0d_out_data", i),  a_out_data,           vecs[i].ed);
         check($sformatf("vec%0d_in_ready", i),  {31'b0, a_in_ready},  {31'b0, vecs[i].erdy});
`ifdef PIPE_STAGE_STATS_EN
         check($sformatf("vec%0d_stall_cnt", i), a_stall_cnt, exp_stall);
         check($sformatf("vec%0d_flush_cnt", i), a_flush_cnt, exp_flushc);
`endif
         prev_v   = vecs[i].ev;
         prev_rdy = vecs[i].erdy;
      end
      a_flush = 1'b0;

      // Reset mid-FULL, with flush also asserted, discards both entries
      a_in_valid = 1'b1; a_out_ready = 1'b0;
      a_in_data = 32'hC1; tick();
      a_in_data = 32'hC2; tick();
      check("full_before_reset_in_ready", {31'b0, a_in_ready}, 32'd0);
      reset = 1'b1; a_flush = 1'b1; a_in_valid = 1'b0;
      tick();
      reset = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
      check("rst_full_out_valid", {31'b0, a_out_valid}, 32'd0);
      check("rst_full_out_data",  a_out_data,           32'd0);
      check("rst_full_in_ready",  {31'b0, a_in_ready},  32'd1);
`ifdef PIPE_STAGE_STATS_EN
      check("rst_full_flush_cnt", a_flush_cnt, 32'd0);
`endif
      tick();
      check("rst_full_no_leak", {31'b0, a_out_valid}, 32'd0);

      // Bubble value: flush on an empty stage
      b_flush = 1'b1;
      tick();
      b_flush = 1'b0;
      check("b_flush_empty_data",  b_out_data,           32'hDEAD);
      check("b_flush_empty_valid", {31'b0, b_out_valid}, 32'd0);
`ifdef PIPE_STAGE_STATS_EN
      check("b_flush_empty_cnt", {28'b0, b_flush_cnt}, 32'd0);
`endif

      // One entry held under 20 stall cycles (4-bit counter saturates)
      b_in_valid = 1'b1; b_in_data = 32'h5A; b_out_ready = 1'b0;
      tick();
      b_in_valid = 1'b0;
      check("b_load_data", b_out_data, 32'h5A);
      for (int c = 1; c <= 20; c++) begin
         tick();
`ifdef PIPE_STAGE_STATS_EN
         if (c == 14) check("b_stall_14", {28'b0, b_stall_cnt}, 32'hE);
         if (c == 15) check("b_stall_15", {28'b0, b_stall_cnt}, 32'hF);
`endif
      end
      check("b_stall_hold_data", b_out_data, 32'h5A);
`ifdef PIPE_STAGE_STATS_EN
      check("b_stall_sat", {28'b0, b_stall_cnt}, 32'hF);
`endif
      b_out_ready = 1'b1;
      tick();
      check("b_drain_data",  b_out_data,           32'hDEAD);
      check("b_drain_valid", {31'b0, b_out_valid}, 32'd0);

      // Flush killing a valid entry
      b_in_valid = 1'b1; b_in_data = 32'h5B; b_out_ready = 1'b0;
      tick();
      b_in_valid = 1'b0; b_flush = 1'b1;
      tick();
      b_flush = 1'b0;
      check("b_flush_full_data", b_out_data, 32'hDEAD);
`ifdef PIPE_STAGE_STATS_EN
      check("b_flush_cnt", {28'b0, b_flush_cnt}, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
